// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the two-digit shift-add multiplier.
// Both the controller and its datapath import this package.
package mult_pkg;

  localparam int DIGIT_W    = 4;
  localparam int PROD_W     = 7;
  localparam int MAX_DIGIT  = 9;
  localparam int BLANK_CODE = 127;
  localparam int N_ITER     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_mult_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
// Sequenced by digit_mult_ctrl through load/step strobes.
module digit_mult_dp #(
  parameter int DIGIT_W = mult_pkg::DIGIT_W,
  parameter int PROD_W  = mult_pkg::PROD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [PROD_W-1:0]  acc
);

  logic [PROD_W-1:0]  mcand;
  logic [DIGIT_W-1:0] mplier;

  // NOTE: these are plain registers, not a memory, so they take a reset value
  // like any other flop and the first operation never sees stale partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PROD_W'(a);
      mplier <= b;
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/digit_mult_ctrl.sv
// Start/done controller for the two-digit multiplier; owns the iteration
// counter and the registered result bus feeding the 7-segment decoder.
module digit_mult_ctrl #(
  parameter int DIGIT_W    = mult_pkg::DIGIT_W,
  parameter int PROD_W     = mult_pkg::PROD_W,
  parameter int MAX_DIGIT  = mult_pkg::MAX_DIGIT,
  parameter int BLANK_CODE = mult_pkg::BLANK_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PROD_W-1:0]  product,
  output logic               product_valid
);

  import mult_pkg::*;

  localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);
  localparam logic [PROD_W-1:0]  BLANK    = PROD_W'(BLANK_CODE);
  localparam logic [1:0]         LAST_CNT = 2'(N_ITER - 1);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q;
  logic               legal;
  logic               load, step, finish, reject;
  logic [PROD_W-1:0]  acc;

  assign legal = (a <= MAX_D) && (b <= MAX_D);

  digit_mult_dp #(
    .DIGIT_W (DIGIT_W),
    .PROD_W  (PROD_W)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a),
    .b    (b),
    .acc  (acc)
  );

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // so register-to-register ordering inside a block never matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            load    = 1'b1;
            state_d = CALC;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (load) cnt_q <= '0;
    else if (step) cnt_q <= cnt_q + 2'd1;
  end

  // Result bus only moves on completion or rejection; it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= finish | reject;
      if (load) err <= 1'b0;
      if (reject) begin
        err           <= 1'b1;
        product       <= BLANK;
        product_valid <= 1'b0;
      end else if (finish) begin
        product       <= acc;
        product_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_mult_ctrl.sv
// Self-checking bench for digit_mult_ctrl: directed table, random operands
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_digit_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done, err, product_valid;
  logic [6:0] product;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  digit_mult_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .product       (product),
    .product_valid (product_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [6:0] exp_product;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; returns cycles elapsed since the start edge.
  task automatic wait_done(input logic [6:0] held, output int lat, output bit hold_ok);
    lat     = 0;
    hold_ok = 1'b1;
    while (lat < 20) begin
      tick();
      lat++;
      if (done) break;
      if (product !== held) hold_ok = 1'b0;
    end
  endtask

  // Reference behaviour: legal operands give a*b after 5 cycles, otherwise an
  // immediate blank code with err and a single done pulse.
  task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_, input string nm);
    logic [6:0] held;
    logic [6:0] exp_p;
    bit         legal;
    int         lat;
    bit         hold_ok;
    legal = (ta <= 9) && (tb_ <= 9);
    exp_p = legal ? 7'(int'(ta) * int'(tb_)) : 7'd127;
    held  = product;
    a = ta; b = tb_; start = 1'b1;
    tick();
    start = 1'b0;
    if (!legal) begin
      check({nm, "_ill_done"},  done, 1);
      check({nm, "_ill_err"},   err, 1);
      check({nm, "_ill_prod"},  product, exp_p);
      check({nm, "_ill_valid"}, product_valid, 0);
      check({nm, "_ill_busy"},  busy, 0);
      tick();
      check({nm, "_ill_done_off"}, done, 0);
      check({nm, "_ill_busy2"},    busy, 0);
      check({nm, "_ill_err_hold"}, err, 1);
    end else begin
      check({nm, "_busy"},    busy, 1);
      check({nm, "_err_clr"}, err, 0);
      wait_done(held, lat, hold_ok);
      check({nm, "_latency"}, lat, 5);
      check({nm, "_hold"},    hold_ok, 1);
      check({nm, "_prod"},    product, exp_p);
      check({nm, "_valid"},   product_valid, 1);
      check({nm, "_busy_off"}, busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ndone;
    int last_cyc;
    bit hold_ok;

    vecs[0] = '{4'd9,  4'd9,  7'd81,  1'b0};
    vecs[1] = '{4'd0,  4'd7,  7'd0,   1'b0};
    vecs[2] = '{4'd3,  4'd4,  7'd12,  1'b0};
    vecs[3] = '{4'd10, 4'd3,  7'd127, 1'b1};
    vecs[4] = '{4'd2,  4'd5,  7'd10,  1'b0};
    vecs[5] = '{4'd15, 4'd15, 7'd127, 1'b1};
    vecs[6] = '{4'd9,  4'd0,  7'd0,   1'b0};
    vecs[7] = '{4'd4,  4'd12, 7'd127, 1'b1};
    vecs[8] = '{4'd1,  4'd1,  7'd1,   1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err, 0);
    check("rst_prod",  product, 0);
    check("rst_valid", product_valid, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_product", i), product, vecs[i].exp_product);
      check($sformatf("vec%0d_errflag", i), err, vecs[i].exp_err);
    end

    // Start held high through an operation with operands changed mid-CALC.
    a = 4'd7; b = 4'd8; start = 1'b1;
    tick();
    check("hold_busy", busy, 1);
    a = 4'd1; b = 4'd1;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) ndone++;
    end
    check("hold_ndone", ndone, 1);
    check("hold_prod",  product, 56);
    tick();
    check("hold_next_busy", busy, 1);
    check("hold_next_done", done, 0);
    start = 1'b0;
    wait_done(7'd56, lat, hold_ok);
    check("hold_next_lat",  lat, 5);
    check("hold_next_prod", product, 1);

    // Reset during iteration 2 of 6x6.
    a = 4'd6; b = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_prod",  product, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  done, 0);
    check("mid_rst_valid", product_valid, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("mid_rst_quiet", ndone, 0);
    do_op(4'd6, 4'd6, "restart");
    check("restart_prod", product, 36);

    // Random operands, biased toward legal values.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      if ($urandom_range(0, 3) != 0) begin
        ra = 4'($urandom_range(0, 9));
        rb = 4'($urandom_range(0, 9));
      end else begin
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
      end
      do_op(ra, rb, $sformatf("rnd%0d", i));
    end

    // Back-to-back sweep of all legal pairs; done spacing must be 6 cycles.
    last_cyc = -1;
    for (int ia = 0; ia < 10; ia++) begin
      for (int ib = 0; ib < 10; ib++) begin
        do_op(4'(ia), 4'(ib), $sformatf("sw%0d_%0d", ia, ib));
        if (last_cyc >= 0) check($sformatf("sw%0d_%0d_spacing", ia, ib), cyc - last_cyc, 6);
        last_cyc = cyc;
      end
    end

    tick();
    check("final_done_off", done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
